// File: rtl/lcd_pixel_ram.sv
// Parametrised LCD pixel/palette RAM: byte-enable write port, NRD registered
// sub-word read ports with write-first bypass, and a word-per-cycle clear engine.

module lcd_pixel_ram_rdport #(
   parameter int DATA_W = 32,
   parameter int SUB_W  = 16,
   parameter int ADDR_W = 7,
   parameter int SEL_W  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req,
   input  logic [ADDR_W+SEL_W-1:0] addr,
   input  logic [DATA_W-1:0]       mem_word,
   input  logic                    wr_en,
   input  logic [ADDR_W-1:0]       wr_word,
   input  logic [DATA_W-1:0]       wr_merged,
   output logic [SUB_W-1:0]        data,
   output logic                    valid
);
   localparam int NSUB = DATA_W / SUB_W;

   logic [DATA_W-1:0] word;
   logic [SUB_W-1:0]  sub;

   // same-edge write to this word: return the post-write value
   assign word = (wr_en && wr_word == addr[SEL_W +: ADDR_W]) ? wr_merged : mem_word;

   generate
      if (SEL_W > 0) begin : g_sel
         always_comb begin
            sub = word[SUB_W-1:0];
            for (int i = 1; i < NSUB; i++)
               if (addr[SEL_W-1:0] == SEL_W'(i)) sub = word[i*SUB_W +: SUB_W];
         end
      end else begin : g_nosel
         assign sub = word;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data  <= '0;
         valid <= 1'b0;
      end else begin
         valid <= req;
         if (req) data <= sub;
      end
   end
endmodule

module lcd_pixel_ram #(
   parameter  int DATA_W = 32,
   parameter  int ADDR_W = 7,
   parameter  int SUB_W  = 16,
   parameter  int NRD    = 2,
   localparam int SEL_W  = $clog2(DATA_W / SUB_W),
   localparam int RA_W   = ADDR_W + SEL_W,
   localparam int BE_W   = DATA_W / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [BE_W-1:0]       wr_be,
   output logic                  wr_drop,
   input  logic [NRD-1:0]        rd_req,
   input  logic [NRD*RA_W-1:0]   rd_addr,
   output logic [NRD*SUB_W-1:0]  rd_data,
   output logic [NRD-1:0]        rd_valid,
   input  logic                  clr_start,
   output logic                  clr_busy,
   output logic                  clr_done
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

   typedef struct packed {
      logic              en;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [BE_W-1:0]   be;
   } wreq_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] cnt, cnt_nx;
   logic              done_nx;
   wreq_t             w;
   logic [DATA_W-1:0] merged;
   logic [DATA_W-1:0] mem [DEPTH];

   assign clr_busy = (state == S_CLEAR);

   // single effective write per edge: the clear engine owns the port while busy
   always_comb begin
      w = '0;
      if (state == S_CLEAR) begin
         w.en   = ~rst;
         w.addr = cnt;
         w.be   = '1;
      end else begin
         w.en   = wr_en & ~rst;
         w.addr = wr_addr;
         w.data = wr_data;
         w.be   = wr_be;
      end
   end

   always_comb begin
      merged = mem[w.addr];
      for (int b = 0; b < BE_W; b++)
         if (w.be[b]) merged[8*b +: 8] = w.data[8*b +: 8];
   end

   always_ff @(posedge clk) begin
      if (w.en) mem[w.addr] <= merged;
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      done_nx  = 1'b0;
      case (state)
         S_IDLE: begin
            if (clr_start) begin
               state_nx = S_CLEAR;
               cnt_nx   = '0;
            end
         end
         S_CLEAR: begin
            cnt_nx = cnt + ADDR_W'(1);
            if (cnt == '1) begin
               state_nx = S_IDLE;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         clr_done <= 1'b0;
         wr_drop  <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         clr_done <= done_nx;
         wr_drop  <= wr_en & (state == S_CLEAR);
      end
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      lcd_pixel_ram_rdport #(
         .DATA_W (DATA_W),
         .SUB_W  (SUB_W),
         .ADDR_W (ADDR_W),
         .SEL_W  (SEL_W)
      ) u_rd (
         .clk       (clk),
         .rst       (rst),
         .req       (rd_req[p]),
         .addr      (rd_addr[p*RA_W +: RA_W]),
         .mem_word  (mem[rd_addr[p*RA_W+SEL_W +: ADDR_W]]),
         .wr_en     (w.en),
         .wr_word   (w.addr),
         .wr_merged (merged),
         .data      (rd_data[p*SUB_W +: SUB_W]),
         .valid     (rd_valid[p])
      );
   end
endmodule

// File: doc/lcd_pixel_ram.md
# lcd_pixel_ram

Parametrised pixel/palette RAM for the LCD controller. Replaces the fixed 128x32, two-port, half-word read memory. Adds:
- configurable width, depth, sub-word size and read-port count;
- byte-enable writes;
- registered reads with a valid strobe and write-first bypass;
- a hardware clear engine that zeroes the array one word per cycle.

It sits between the bus-side frame/palette loader (write port) and the pixel-fetch pipelines (read ports).

## Interface
Parameters:
- DATA_W, 32, word width in bits; multiple of 8 and of SUB_W.
- ADDR_W, 7, word address width; depth = 2**ADDR_W.
- SUB_W, 16, read sub-word width; DATA_W/SUB_W is a power of two.
- NRD, 2, number of independent read ports.
- Derived: SEL_W = log2(DATA_W/SUB_W) (0 allowed), RA_W = ADDR_W+SEL_W, BE_W = DATA_W/8.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write word address.
- wr_data  in  DATA_W  write data.
- wr_be  in  BE_W  byte enables; bit i covers wr_data[8i+7:8i].
- wr_drop  out  1  pulses when a write is discarded because a clear is running.
- rd_req  in  NRD  per-port read request.
- rd_addr  in  NRD*RA_W  per-port address; port p in slice [p*RA_W +: RA_W]; low SEL_W bits select the sub-word, upper ADDR_W bits select the word.
- rd_data  out  NRD*SUB_W  per-port read sub-word.
- rd_valid  out  NRD  per-port data-valid strobe.
- clr_start  in  1  start a full-array clear.
- clr_busy  out  1  clear engine active.
- clr_done  out  1  one-cycle pulse on completion of a clear.

## Operation
- **Array:** 2**ADDR_W words of DATA_W bits. It is not reset. Contents are undefined until written or cleared.
- **Write:** on an edge with wr_en=1 and clr_busy=0, each byte with wr_be=1 is updated. Bytes with wr_be=0 keep their value. wr_be=0 is a legal no-op.
- **Clear FSM:** two states, IDLE and CLEAR.
  - IDLE -> CLEAR on an edge with clr_start=1. The counter loads 0.
  - In CLEAR, every edge writes all-zero to word[counter] and increments the counter.
  - On the edge that writes word 2**ADDR_W-1, the FSM returns to IDLE and clr_done=1 for the following cycle.
  - clr_start while in CLEAR is ignored.
  - A clear takes exactly 2**ADDR_W cycles.
- **Writes during CLEAR:** wr_en=1 while clr_busy=1 is dropped. wr_drop=1 for the cycle after that edge. The array is unaffected except by the clear.
- **Read, per port independently:** on an edge with rd_req[p]=1, the addressed word is captured and sub-word sel (sel=0 means bits [SUB_W-1:0]) is registered to rd_data[p]. rd_valid[p]=1 that cycle.
  - When rd_req[p]=0, rd_valid[p]=0 and rd_data[p] holds its last value.
- **Write-first bypass:** if a read and a write (external or clear) target the same word on the same edge, the read returns the post-write value.
  - Enabled bytes come from new data (zero for a clear); other bytes come from the old array content.
- Reads are allowed during CLEAR and see the array as it stands, including the bypass above.
- Any number of ports may read the same address simultaneously.

## Timing
- **Reset values:** rd_data=0, rd_valid=0, clr_busy=0, clr_done=0, wr_drop=0. FSM=IDLE, counter=0.
- **Reset mid-clear:** the FSM aborts to IDLE and no clr_done is issued. Words already cleared stay zero; the rest are unchanged.
- **Read latency:** 1 cycle. A request sampled at edge N gives data valid from just after edge N until edge N+1.
- **Back-to-back reads:** one read per port per cycle, with no bubbles.
- **Write visibility:** a write at edge N is visible to a read sampled at edge N (bypass) and at any later edge.
- clr_busy rises after the edge sampling clr_start and falls after the edge writing the last word. clr_done is coincident with the first cycle of clr_busy=0.
- **Simultaneous clr_start and wr_en in IDLE:** the write is performed, since clr_busy is still 0. The clear starts on the same edge.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- **Write then read, default params:** write 0xDEADBEEF to word 5 with wr_be=0xF. Next cycle read rd_addr=0x0A on port 0 and 0x0B on port 1 -> one cycle later rd_data0=0xBEEF, rd_data1=0xDEAD, rd_valid=2'b11.
- **Byte enables:** word 3 holds 0x11223344. Write 0xAABBCCDD with wr_be=4'b0101 -> word 3 reads 0x11BB33DD.
- **Read-during-write bypass:** word 7 holds 0. On the same edge write 0x12345678 (wr_be=0xF) and read rd_addr=0x0E -> rd_data=0x5678 next cycle, not 0.
- **Full clear:** fill the array with nonzero data and pulse clr_start.
  - Required: clr_busy high for exactly 128 cycles, clr_done for 1 cycle.
  - Required: all 256 sub-words read 0 afterwards.
  - Required: a wr_en mid-clear gives wr_drop=1 and that word reads 0.
- **Reset mid-clear:** assert rst 40 cycles into a clear -> clr_busy=0 and rd_valid=0 immediately; no clr_done; words 0-39 read 0; word 100 retains its prior value.
- **Parametrised build:** DATA_W=32, SUB_W=8, NRD=3, ADDR_W=4 -> write 0x04030201 to word 2; read addresses 8, 9, 11 -> 0x01, 0x02, 0x04 on ports 0-2.
